// File: rtl/fifo_arbiter.sv
// Two-requester round-robin writer into an external FIFO RAM, plus a read
// sequencer that drains the FIFO into a single held output register.
module fifo_arbiter #(
    parameter int DEPTH = 16384
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  req0_data,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req1_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    output logic [7:0]  fifo_data_in,
    output logic        fifo_write,
    output logic        fifo_read,
    output logic        fifo_enable,
    input  logic [7:0]  fifo_data_out,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        last_grant,
    output logic [14:0] occupancy,
    output logic [15:0] count0,
    output logic [15:0] count1,
    output logic [1:0]  dbg_state
);

    // Handshakes: a requester byte moves when reqN_valid && reqN_ready; the
    // consumer byte moves when out_valid && out_ready, both on the same posedge.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_HOLD = 2'd2
    } rd_state_t;

    localparam logic [14:0] OCC_MAX = 15'(DEPTH + 1);

    rd_state_t   r_state;
    rd_state_t   w_next_state;
    logic        r_last_grant;
    logic [15:0] r_count0;
    logic [15:0] r_count1;
    logic [14:0] r_occupancy;
    logic [7:0]  r_out_data;
    logic        w_grant_idx;
    logic        w_accept;
    logic        w_read;
    logic        w_handshake;

    // Contention goes to whichever requester did not win last time.
    always_comb begin
        w_grant_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_idx = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_idx = 1'b1;
        end
    end

    assign w_accept     = reset && !fifo_full && (req0_valid || req1_valid);
    assign req0_ready   = w_accept && !w_grant_idx;
    assign req1_ready   = w_accept && w_grant_idx;
    assign fifo_write   = w_accept;
    assign fifo_data_in = req1_ready ? req1_data : req0_data;
    assign fifo_enable  = reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
            r_count0     <= 16'd0;
            r_count1     <= 16'd0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_idx;
            if (w_grant_idx) begin
                r_count1 <= r_count1 + 16'd1;
            end else begin
                r_count0 <= r_count0 + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            R_IDLE:  if (!fifo_empty) w_next_state = R_WAIT;
            R_WAIT:  w_next_state = R_HOLD;
            R_HOLD:  if (out_ready) w_next_state = fifo_empty ? R_IDLE : R_WAIT;
            default: w_next_state = R_IDLE;
        endcase
    end

    // A read issued in R_HOLD on the handshake cycle keeps the rate at one byte per two cycles.
    always_comb begin
        w_read    = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            R_IDLE:  w_read = !fifo_empty;
            R_HOLD: begin
                out_valid = 1'b1;
                w_read    = out_ready && !fifo_empty;
            end
            default: w_read = 1'b0;
        endcase
    end

    assign fifo_read   = reset && w_read;
    assign w_handshake = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out_data <= 8'd0;
        end else if (r_state == R_WAIT) begin
            r_out_data <= fifo_data_out;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_occupancy <= 15'd0;
        end else if (w_accept && !w_handshake && (r_occupancy != OCC_MAX)) begin
            r_occupancy <= r_occupancy + 15'd1;
        end else if (w_handshake && !w_accept && (r_occupancy != 15'd0)) begin
            r_occupancy <= r_occupancy - 15'd1;
        end
    end

    assign out_data   = r_out_data;
    assign last_grant = r_last_grant;
    assign occupancy  = r_occupancy;
    assign count0     = r_count0;
    assign count1     = r_count1;
    assign dbg_state  = r_state;

endmodule
